// File: rtl/score_scan_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : score_scan_pkg
// Desc   : Score RAM geometry and scanner FSM encodings shared across blocks
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package score_scan_pkg;

   localparam int SCORE_ADDR_W = 4;
   localparam int SCORE_DATA_W = 4;
   localparam int SCORE_RD_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      QUERY = 2'd2
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/score_scan_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : score_scan_acc
// Desc   : Running max/ID/non-zero-count/sum over captured score entries
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module score_scan_acc
   import score_scan_pkg::*;
#(
   parameter int ADDR_W = SCORE_ADDR_W,
   parameter int DATA_W = SCORE_DATA_W
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     en,
   input  logic                     publish,
   input  logic [DATA_W-1:0]        q,
   input  logic [ADDR_W-1:0]        id,
   output logic [DATA_W-1:0]        max_score,
   output logic [ADDR_W-1:0]        max_id,
   output logic [ADDR_W:0]          nz_count,
   output logic [ADDR_W+DATA_W-1:0] sum_score
);

   localparam logic [ADDR_W:0] c_nz_one = (ADDR_W+1)'(1);

   logic [DATA_W-1:0]        r_run_max;
   logic [ADDR_W-1:0]        r_run_id;
   logic [ADDR_W:0]          r_run_nz;
   logic [ADDR_W+DATA_W-1:0] r_run_sum;

   logic                     w_upd;
   logic [DATA_W-1:0]        w_nxt_max;
   logic [ADDR_W-1:0]        w_nxt_id;
   logic [ADDR_W:0]          w_nxt_nz;
   logic [ADDR_W+DATA_W-1:0] w_nxt_sum;

   // Strict compare: entries arrive in ascending ID order, so ties keep the lowest ID.
   always_comb begin
      w_upd     = en && (q > r_run_max);
      w_nxt_max = w_upd ? q  : r_run_max;
      w_nxt_id  = w_upd ? id : r_run_id;
      w_nxt_nz  = (en && (q != '0)) ? (r_run_nz + c_nz_one) : r_run_nz;
      w_nxt_sum = en ? (r_run_sum + {{ADDR_W{1'b0}}, q}) : r_run_sum;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_run_max <= '0;
         r_run_id  <= '0;
         r_run_nz  <= '0;
         r_run_sum <= '0;
         max_score <= '0;
         max_id    <= '0;
         nz_count  <= '0;
         sum_score <= '0;
      end else begin
         if (clear) begin
            r_run_max <= '0;
            r_run_id  <= '0;
            r_run_nz  <= '0;
            r_run_sum <= '0;
         end else begin
            r_run_max <= w_nxt_max;
            r_run_id  <= w_nxt_id;
            r_run_nz  <= w_nxt_nz;
            r_run_sum <= w_nxt_sum;
         end
         // Publishing on the final capture folds that entry in without an extra stage.
         if (publish) begin
            max_score <= w_nxt_max;
            max_id    <= w_nxt_id;
            nz_count  <= w_nxt_nz;
            sum_score <= w_nxt_sum;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/score_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : score_scan
// Desc   : Score RAM scanner (max/ID/count/sum) with single-ID lookup port
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module score_scan
   import score_scan_pkg::*;
#(
   parameter int ADDR_W = SCORE_ADDR_W,
   parameter int DATA_W = SCORE_DATA_W,
   parameter int RD_LAT = SCORE_RD_LAT
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     query_req,
   input  logic [ADDR_W-1:0]        query_id,
   input  logic [DATA_W-1:0]        ram_q,
   output logic [ADDR_W-1:0]        ram_address,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_W-1:0]        max_score,
   output logic [ADDR_W-1:0]        max_id,
   output logic [ADDR_W:0]          nz_count,
   output logic [ADDR_W+DATA_W-1:0] sum_score,
   output logic [DATA_W-1:0]        query_score,
   output logic                     query_valid
);

   localparam logic [ADDR_W-1:0] c_last_addr = '1;
   localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

   scan_state_t       r_state;
   scan_state_t       w_next_state;

   logic [ADDR_W-1:0] r_addr;
   logic              r_addr_done;
   logic              r_q_issued;
   logic              r_busy;
   logic              r_done;
   logic              r_qvalid;
   logic [DATA_W-1:0] r_qscore;
   logic [RD_LAT-1:0] r_vld_sr;
   logic [RD_LAT-1:0] r_qvld_sr;
   logic [ADDR_W-1:0] r_id_sr [RD_LAT];

   logic              w_start_scan;
   logic              w_start_query;
   logic              w_scan_issue;
   logic              w_q_issue;
   logic              w_take;
   logic              w_take_last;
   logic              w_q_take;

   assign w_scan_issue = (r_state == SCAN) && !r_addr_done;
   assign w_q_issue    = (r_state == QUERY) && !r_q_issued;
   assign w_take       = r_vld_sr[RD_LAT-1];
   assign w_take_last  = w_take && (r_id_sr[RD_LAT-1] == c_last_addr);
   assign w_q_take     = r_qvld_sr[RD_LAT-1];

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      w_start_scan  = 1'b0;
      w_start_query = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = SCAN;
               w_start_scan = 1'b1;
            end else if (query_req) begin
               w_next_state  = QUERY;
               w_start_query = 1'b1;
            end
         end
         SCAN:    if (w_take_last) w_next_state = IDLE;
         QUERY:   if (w_q_take)    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr      <= '0;
         r_addr_done <= 1'b0;
         r_q_issued  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_qvalid    <= 1'b0;
         r_qscore    <= '0;
         r_vld_sr    <= '0;
         r_qvld_sr   <= '0;
         for (int i = 0; i < RD_LAT; i++) r_id_sr[i] <= '0;
      end else begin
         r_busy   <= (w_next_state != IDLE);
         r_done   <= w_take_last;
         r_qvalid <= w_q_take;
         if (w_q_take) r_qscore <= ram_q;

         // Tags enter when an address has been on the bus for one cycle, so they
         // emerge exactly when the RAM returns that address's data.
         r_vld_sr[0]  <= w_scan_issue;
         r_qvld_sr[0] <= w_q_issue;
         r_id_sr[0]   <= r_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld_sr[i]  <= r_vld_sr[i-1];
            r_qvld_sr[i] <= r_qvld_sr[i-1];
            r_id_sr[i]   <= r_id_sr[i-1];
         end

         if (w_start_scan) begin
            r_addr      <= '0;
            r_addr_done <= 1'b0;
         end else if (w_start_query) begin
            r_addr     <= query_id;
            r_q_issued <= 1'b0;
         end else if (w_scan_issue) begin
            if (r_addr == c_last_addr) r_addr_done <= 1'b1;
            else                       r_addr      <= r_addr + c_addr_one;
         end
         if (w_q_issue) r_q_issued <= 1'b1;
      end
   end

   score_scan_acc #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_acc (
      .clk       (clk),
      .reset     (reset),
      .clear     (w_start_scan),
      .en        (w_take),
      .publish   (w_take_last),
      .q         (ram_q),
      .id        (r_id_sr[RD_LAT-1]),
      .max_score (max_score),
      .max_id    (max_id),
      .nz_count  (nz_count),
      .sum_score (sum_score)
   );

   assign ram_address = r_addr;
   assign busy        = r_busy;
   assign done        = r_done;
   assign query_score = r_qscore;
   assign query_valid = r_qvalid;

endmodule
`default_nettype wire

// File: tb/tb_score_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_score_scan
// Desc   : Self-checking bench for score_scan with a synchronous-read RAM model
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_score_scan;
   import score_scan_pkg::*;

   localparam int AW = SCORE_ADDR_W;
   localparam int DW = SCORE_DATA_W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          query_req = 1'b0;
   logic [AW-1:0] query_id = '0;
   logic [DW-1:0] ram_q;
   logic [AW-1:0] ram_address;
   logic          busy, done, query_valid;
   logic [DW-1:0] max_score, query_score;
   logic [AW-1:0] max_id;
   logic [AW:0]   nz_count;
   logic [AW+DW-1:0] sum_score;

   logic [DW-1:0] mem [16];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [7:0] last_sum = '0;

   typedef struct {
      logic [3:0] mx;
      logic [3:0] id;
      logic [4:0] nz;
      logic [7:0] sum;
   } scan_exp_t;

   typedef struct {
      int        kind;
      scan_exp_t exp;
   } vec_t;

   scan_exp_t  sq[$];
   logic [3:0] qq[$];

   score_scan dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .query_req   (query_req),
      .query_id    (query_id),
      .ram_q       (ram_q),
      .ram_address (ram_address),
      .busy        (busy),
      .done        (done),
      .max_score   (max_score),
      .max_id      (max_id),
      .nz_count    (nz_count),
      .sum_score   (sum_score),
      .query_score (query_score),
      .query_valid (query_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      ram_q <= mem[ram_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: results are compared whenever the DUT announces them.
   always @(negedge clk) begin : mon
      scan_exp_t  e;
      logic [3:0] qe;
      if (!reset && done) begin
         check("done_expected", 32'(sq.size() > 0), 32'd1);
         if (sq.size() > 0) begin
            e = sq.pop_front();
            check("max_score", 32'(max_score), 32'(e.mx));
            check("max_id",    32'(max_id),    32'(e.id));
            check("nz_count",  32'(nz_count),  32'(e.nz));
            check("sum_score", 32'(sum_score), 32'(e.sum));
         end
      end
      if (!reset && query_valid) begin
         check("qvalid_expected", 32'(qq.size() > 0), 32'd1);
         if (qq.size() > 0) begin
            qe = qq.pop_front();
            check("query_score", 32'(query_score), 32'(qe));
         end
      end
   end

   task automatic load_pattern(input int kind);
      for (int i = 0; i < 16; i++) begin
         case (kind)
            0:       mem[i] = 4'(i);
            1:       mem[i] = (i == 3 || i == 9) ? 4'd12 : 4'd0;
            2:       mem[i] = 4'd0;
            3:       mem[i] = 4'd15;
            default: mem[i] = 4'(15 - i);
         endcase
      end
   endtask

   task automatic run_scan(input scan_exp_t e);
      int t0;
      bit seen;
      @(negedge clk);
      start = 1'b1;
      sq.push_back(e);
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (k == 3) check("results_hold", 32'(sum_score), 32'(last_sum));
         if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
      if (seen) check("scan_latency", 32'(cyc - t0), 32'd18);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
      last_sum = e.sum;
   endtask

   task automatic run_query(input logic [3:0] id, input logic [3:0] exp_score);
      int t_acc;
      bit seen;
      @(negedge clk);
      query_req = 1'b1;
      query_id  = id;
      qq.push_back(exp_score);
      t_acc = cyc + 1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (query_valid) seen = 1'b1;
      end
      query_req = 1'b0;
      check("qvalid_seen", 32'(seen), 32'd1);
      if (seen) check("query_latency", 32'(cyc - t_acc), 32'd2);
      @(negedge clk);
      check("qvalid_one_cycle", 32'(query_valid), 32'd0);
      check("query_score_hold", 32'(query_score), 32'(exp_score));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   nd, nb, t0;
      bit   seen;

      vecs[0] = '{kind: 0, exp: '{mx: 4'd15, id: 4'd15, nz: 5'd15, sum: 8'd120}};
      vecs[1] = '{kind: 1, exp: '{mx: 4'd12, id: 4'd3,  nz: 5'd2,  sum: 8'd24}};
      vecs[2] = '{kind: 2, exp: '{mx: 4'd0,  id: 4'd0,  nz: 5'd0,  sum: 8'd0}};
      vecs[3] = '{kind: 3, exp: '{mx: 4'd15, id: 4'd0,  nz: 5'd16, sum: 8'd240}};
      vecs[4] = '{kind: 4, exp: '{mx: 4'd15, id: 4'd0,  nz: 5'd15, sum: 8'd120}};

      load_pattern(2);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ram_address", 32'(ram_address), 32'd0);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_done",        32'(done),        32'd0);
      check("rst_max_score",   32'(max_score),   32'd0);
      check("rst_max_id",      32'(max_id),      32'd0);
      check("rst_nz_count",    32'(nz_count),    32'd0);
      check("rst_sum_score",   32'(sum_score),   32'd0);
      check("rst_query_score", 32'(query_score), 32'd0);
      check("rst_query_valid", 32'(query_valid), 32'd0);

      nd = 0; nb = 0;
      repeat (50) begin
         @(negedge clk);
         nd += int'(done);
         nb += int'(busy);
      end
      check("idle_done_count", 32'(nd), 32'd0);
      check("idle_busy_count", 32'(nb), 32'd0);

      for (int v = 0; v < 5; v++) begin
         load_pattern(vecs[v].kind);
         run_scan(vecs[v].exp);
      end

      // Single-ID lookups, back to back.
      load_pattern(2);
      mem[6] = 4'd7;
      mem[0] = 4'd9;
      run_query(4'd6, 4'd7);
      run_query(4'd0, 4'd9);
      check("results_after_query", 32'(sum_score), 32'(last_sum));

      // Start and query together: scan first, then the held query; start during QUERY ignored.
      load_pattern(0);
      mem[2] = 4'd5;
      @(negedge clk);
      start = 1'b1;
      query_req = 1'b1;
      query_id = 4'd2;
      sq.push_back('{mx: 4'd15, id: 4'd15, nz: 5'd15, sum: 8'd123});
      qq.push_back(4'd5);
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         if (!seen) nd += int'(query_valid);
      end
      check("both_done_seen", 32'(seen), 32'd1);
      if (seen) check("both_scan_latency", 32'(cyc - t0), 32'd18);
      @(negedge clk);
      check("query_after_scan_busy", 32'(busy), 32'd1);
      check("query_not_yet_valid", 32'(query_valid), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("query_after_scan_valid", 32'(query_valid), 32'd1);
      query_req = 1'b0;
      last_sum = 8'd123;
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         nd += int'(done);
      end
      check("start_in_query_ignored", 32'(nd), 32'd0);
      check("idle_after_query", 32'(busy), 32'd0);

      // Reset in the middle of a scan aborts it and clears the published results.
      load_pattern(0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      repeat (7) begin
         @(negedge clk);
         nd += int'(done);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("abort_max_score", 32'(max_score), 32'd0);
      check("abort_max_id",    32'(max_id),    32'd0);
      check("abort_nz_count",  32'(nz_count),  32'd0);
      check("abort_sum_score", 32'(sum_score), 32'd0);
      check("abort_busy",      32'(busy),      32'd0);
      check("abort_address",   32'(ram_address), 32'd0);
      repeat (25) begin
         @(negedge clk);
         nd += int'(done);
      end
      check("abort_no_done", 32'(nd), 32'd0);
      last_sum = 8'd0;
      run_scan(vecs[0].exp);

      check("scan_queue_drained",  32'(sq.size()), 32'd0);
      check("query_queue_drained", 32'(qq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
